// File: rtl/shift_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_display_ctrl
// Summary  : Debounced-button shift register with a multiplexed hex display.
// Revision : 1.0
// ============================================================================
module shift_display_ctrl #(
    parameter int DATA_W    = 8,
    parameter int SCAN_BITS = 18,
    parameter int DB_COUNT  = 500000
) (
    input  logic                      mclk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         sw,
    input  logic [3:0]                btn,
    input  logic [$clog2(DATA_W)-1:0] amt,
    output logic [0:6]                seg,
    output logic                      dp,
    output logic [DATA_W/2-1:0]       an,
    output logic [DATA_W-1:0]         shift_q,
    output logic [1:0]                mode_q
);
    localparam int c_AMT_W = $clog2(DATA_W);
    localparam int c_NDIG  = DATA_W / 2;
    localparam int c_DIG_W = $clog2(c_NDIG);
    localparam int c_DB_W  = $clog2(DB_COUNT + 1);
    localparam logic [c_AMT_W:0] c_W_EXT = (c_AMT_W + 1)'(DATA_W);

    typedef enum logic [1:0] {
        MODE_LOG = 2'b00,
        MODE_ROT = 2'b01,
        MODE_ARI = 2'b10
    } mode_t;

    logic [DATA_W-1:0] r_sw_s1, r_sw_s2;
    logic [3:0]        r_btn_s1, r_btn_s2;
    logic [1:0]        r_vld;
    logic [3:0]        w_pulse;

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_vld    <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
            r_vld    <= {r_vld[0], 1'b1};
        end
    end

    // A button only becomes armed once it has been seen released after reset,
    // so a button held through reset cannot fire until pressed again.
    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [c_DB_W-1:0] r_cnt;
        logic              r_level, r_prev, r_armed, r_pls;

        always_ff @(posedge mclk) begin
            if (reset) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_prev  <= 1'b0;
                r_armed <= 1'b0;
                r_pls   <= 1'b0;
            end else begin
                r_prev <= r_level;
                r_pls  <= r_level & ~r_prev & r_armed;
                if (r_vld[1] && !r_btn_s2[i])
                    r_armed <= 1'b1;
                if (r_btn_s2[i] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_W'(DB_COUNT - 1)) begin
                    r_cnt   <= '0;
                    r_level <= r_btn_s2[i];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_pulse[i] = r_pls;
    end

    mode_t               r_mode, w_mode_next;
    logic [DATA_W-1:0]   r_shift, w_shift_next;
    logic                r_lost, w_lost_next;
    logic [c_AMT_W-1:0]  w_n;
    logic [DATA_W-1:0]   w_ones, w_rol, w_ror, w_sra;
    logic [2*DATA_W-1:0] w_rol_full, w_ror_full;

    assign w_n        = c_AMT_W'({1'b0, amt} % c_W_EXT);
    assign w_ones     = '1;
    assign w_rol_full = {r_shift, r_shift} << w_n;
    assign w_ror_full = {r_shift, r_shift} >> w_n;
    assign w_rol      = w_rol_full[2*DATA_W-1:DATA_W];
    assign w_ror      = w_ror_full[DATA_W-1:0];
    assign w_sra      = $signed(r_shift) >>> w_n;

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_mode  <= MODE_LOG;
            r_shift <= '0;
            r_lost  <= 1'b0;
        end else begin
            r_mode  <= w_mode_next;
            r_shift <= w_shift_next;
            r_lost  <= w_lost_next;
        end
    end

    // Priority: load > left > right > mode step.
    always_comb begin
        w_mode_next  = r_mode;
        w_shift_next = r_shift;
        w_lost_next  = r_lost;
        if (w_pulse[2]) begin
            w_shift_next = r_sw_s2;
            w_lost_next  = 1'b0;
        end else if (w_pulse[1]) begin
            if (r_mode == MODE_ROT) begin
                w_shift_next = w_rol;
            end else begin
                w_shift_next = r_shift << w_n;
                w_lost_next  = r_lost | (|(r_shift & ~(w_ones >> w_n)));
            end
        end else if (w_pulse[0]) begin
            case (r_mode)
                MODE_ROT: w_shift_next = w_ror;
                MODE_ARI: w_shift_next = w_sra;
                default:  w_shift_next = r_shift >> w_n;
            endcase
            if (r_mode != MODE_ROT)
                w_lost_next = r_lost | (|(r_shift & ~(w_ones << w_n)));
        end else if (w_pulse[3]) begin
            case (r_mode)
                MODE_LOG: w_mode_next = MODE_ROT;
                MODE_ROT: w_mode_next = MODE_ARI;
                default:  w_mode_next = MODE_LOG;
            endcase
        end
    end

    assign shift_q = r_shift;
    assign mode_q  = r_mode;

    logic [SCAN_BITS-1:0] r_pre;
    logic [c_DIG_W-1:0]   r_dig;
    logic [2*DATA_W-1:0]  w_disp;
    logic [3:0]           w_nib;
    logic [0:6]           w_seg, r_seg;
    logic [c_NDIG-1:0]    r_an;
    logic                 r_dp;

    // Digit d shows nibble d of {register, switches}.
    assign w_disp = {r_shift, r_sw_s2};
    assign w_nib  = w_disp[{r_dig, 2'b00} +: 4];

    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            default: w_seg = 7'b0111000;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_pre <= '0;
            r_dig <= '0;
            r_an  <= '1;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
            if (&r_pre)
                r_dig <= (r_dig == c_DIG_W'(c_NDIG - 1)) ? '0 : r_dig + 1'b1;
            r_an  <= ~(c_NDIG'(1) << r_dig);
            r_seg <= w_seg;
            r_dp  <= ~(r_lost && (r_dig == c_DIG_W'(DATA_W / 4)));
        end
    end

    assign seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_shift_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_display_ctrl
// Summary  : Self-checking bench for shift_display_ctrl with a reference model.
// Revision : 1.0
// ============================================================================
module tb_shift_display_ctrl;
    localparam int DATA_W    = 8;
    localparam int SCAN_BITS = 2;
    localparam int DB_COUNT  = 4;

    logic       mclk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic [3:0] btn;
    logic [2:0] amt;
    logic [0:6] seg;
    logic       dp;
    logic [3:0] an;
    logic [7:0] shift_q;
    logic [1:0] mode_q;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: register value, mode index 0..2, sticky loss flag.
    logic [7:0] m_q;
    int         m_mode;
    bit         m_lost;

    shift_display_ctrl #(
        .DATA_W   (DATA_W),
        .SCAN_BITS(SCAN_BITS),
        .DB_COUNT (DB_COUNT)
    ) dut (
        .mclk   (mclk),
        .reset  (reset),
        .sw     (sw),
        .btn    (btn),
        .amt    (amt),
        .seg    (seg),
        .dp     (dp),
        .an     (an),
        .shift_q(shift_q),
        .mode_q (mode_q)
    );

    always #5 mclk = ~mclk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    function automatic logic [0:6] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Bit-by-bit shift: result bit i takes source bit i+n (right) or i-n (left).
    function automatic logic [7:0] ref_shift(input logic [7:0] q, input int n,
                                             input bit left, input int mode,
                                             output bit lost);
        logic [7:0] r;
        lost = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int src;
            src = left ? i - n : i + n;
            if (mode == 1)                r[i] = q[(src + 8) % 8];
            else if (src >= 0 && src < 8) r[i] = q[src];
            else                          r[i] = (!left && mode == 2) ? q[7] : 1'b0;
        end
        if (mode != 1)
            for (int j = 0; j < 8; j++)
                if (q[j] && (left ? (j >= 8 - n) : (j < n))) lost = 1'b1;
        return r;
    endfunction

    task automatic model_cmd(input logic [3:0] b);
        bit l;
        if (b[2]) begin
            m_q = sw; m_lost = 1'b0;
        end else if (b[1]) begin
            m_q = ref_shift(m_q, int'(amt), 1'b1, m_mode, l); m_lost |= l;
        end else if (b[0]) begin
            m_q = ref_shift(m_q, int'(amt), 1'b0, m_mode, l); m_lost |= l;
        end else if (b[3]) begin
            m_mode = (m_mode + 1) % 3;
        end
    endtask

    // Clean press of the buttons in b (all together), then release and settle.
    task automatic do_cmd(input logic [3:0] b);
        btn = btn | b;
        tick(8);
        btn = btn & ~b;
        tick(8);
    endtask

    task automatic grab_digit(input int d, output bit ok, output logic [0:6] s,
                              output logic p);
        logic [3:0] pat;
        pat = ~(4'b0001 << d);
        ok = 1'b0; s = 7'b1111111; p = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (an === pat) begin
                ok = 1'b1; s = seg; p = dp;
            end else begin
                tick(1);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sw = 8'h00; btn = 4'h0; amt = 3'd0;
        tick(3);
        n_vec++; if (an !== 4'hF) begin n_err++; $display("FAIL rst_an: got %b exp 1111", an); end
        n_vec++; if (seg !== 7'b1111111) begin n_err++; $display("FAIL rst_seg: got %b exp 1111111", seg); end
        n_vec++; if (dp !== 1'b1) begin n_err++; $display("FAIL rst_dp: got %b exp 1", dp); end
        n_vec++; if (shift_q !== 8'h00) begin n_err++; $display("FAIL rst_q: got %h exp 00", shift_q); end
        n_vec++; if (mode_q !== 2'b00) begin n_err++; $display("FAIL rst_mode: got %b exp 00", mode_q); end
        reset = 1'b0;
        tick(1);
        n_vec++; if (an !== 4'b1110 || seg !== hex7(4'h0))
            begin n_err++; $display("FAIL rst_first: got an %b seg %b exp 1110 %b", an, seg, hex7(4'h0)); end
        m_q = 8'h00; m_mode = 0; m_lost = 1'b0;
        tick(4);
    endtask

    task automatic test_load();
        bit ok; logic [0:6] s; logic p;
        sw = 8'hA5;
        btn[2] = 1'b1;
        tick(7);
        n_vec++; if (shift_q !== 8'h00) begin n_err++; $display("FAIL load_early: got %h exp 00", shift_q); end
        tick(1);
        n_vec++; if (shift_q !== 8'hA5) begin n_err++; $display("FAIL load_lat: got %h exp a5", shift_q); end
        btn[2] = 1'b0;
        tick(8);
        model_cmd(4'b0100);
        grab_digit(2, ok, s, p);
        n_vec++; if (!ok || s !== hex7(4'h5) || p !== 1'b1)
            begin n_err++; $display("FAIL load_dig2: got ok %0d seg %b dp %b exp seg %b dp 1", ok, s, p, hex7(4'h5)); end
        grab_digit(3, ok, s, p);
        n_vec++; if (!ok || s !== hex7(4'hA))
            begin n_err++; $display("FAIL load_dig3: got ok %0d seg %b exp %b", ok, s, hex7(4'hA)); end
    endtask

    task automatic test_bounce();
        sw = 8'h80; amt = 3'd1;
        do_cmd(4'b0100); model_cmd(4'b0100);
        for (int i = 0; i < 10; i++) begin
            btn[0] = ~btn[0];
            tick(2);
        end
        n_vec++; if (shift_q !== 8'h80) begin n_err++; $display("FAIL bounce_none: got %h exp 80", shift_q); end
        btn[0] = 1'b1;
        tick(7);
        n_vec++; if (shift_q !== 8'h80) begin n_err++; $display("FAIL bounce_early: got %h exp 80", shift_q); end
        tick(1);
        n_vec++; if (shift_q !== 8'h40) begin n_err++; $display("FAIL bounce_shift: got %h exp 40", shift_q); end
        tick(20);
        n_vec++; if (shift_q !== 8'h40) begin n_err++; $display("FAIL bounce_once: got %h exp 40", shift_q); end
        btn[0] = 1'b0;
        tick(8);
        model_cmd(4'b0001);
    endtask

    task automatic test_modes();
        bit ok; logic [0:6] s; logic p;
        logic [7:0] exp_r [3];
        exp_r[0] = 8'h4B; exp_r[1] = 8'h4B; exp_r[2] = 8'hCB;
        amt = 3'd1;
        for (int m = 0; m < 3; m++) begin
            n_vec++; if (mode_q !== 2'(m)) begin n_err++; $display("FAIL mode_idx%0d: got %b exp %0d", m, mode_q, m); end
            sw = 8'h96; do_cmd(4'b0100); model_cmd(4'b0100);
            do_cmd(4'b0001); model_cmd(4'b0001);
            n_vec++; if (shift_q !== exp_r[m]) begin n_err++; $display("FAIL mode%0d_right: got %h exp %h", m, shift_q, exp_r[m]); end
            if (m == 0) begin
                grab_digit(2, ok, s, p);
                n_vec++; if (!ok || p !== 1'b1) begin n_err++; $display("FAIL log_right_dp: got ok %0d dp %b exp 1", ok, p); end
            end
            do_cmd(4'b1000); model_cmd(4'b1000);
        end
        n_vec++; if (mode_q !== 2'b00) begin n_err++; $display("FAIL mode_wrap: got %b exp 00", mode_q); end
        amt = 3'd3; sw = 8'h81;
        do_cmd(4'b0100); model_cmd(4'b0100);
        do_cmd(4'b0010); model_cmd(4'b0010);
        n_vec++; if (shift_q !== 8'h08) begin n_err++; $display("FAIL log_left: got %h exp 08", shift_q); end
        grab_digit(2, ok, s, p);
        n_vec++; if (!ok || p !== 1'b0) begin n_err++; $display("FAIL lost_dp2: got ok %0d dp %b exp 0", ok, p); end
        grab_digit(0, ok, s, p);
        n_vec++; if (!ok || p !== 1'b1) begin n_err++; $display("FAIL lost_dp0: got ok %0d dp %b exp 1", ok, p); end
        do_cmd(4'b1000); model_cmd(4'b1000);
        do_cmd(4'b0100); model_cmd(4'b0100);
        do_cmd(4'b0010); model_cmd(4'b0010);
        n_vec++; if (shift_q !== 8'h0C) begin n_err++; $display("FAIL rot_left: got %h exp 0c", shift_q); end
        grab_digit(2, ok, s, p);
        n_vec++; if (!ok || p !== 1'b1) begin n_err++; $display("FAIL rot_dp2: got ok %0d dp %b exp 1", ok, p); end
    endtask

    task automatic test_priority();
        sw = 8'h3C; amt = 3'd2;
        do_cmd(4'b0110); model_cmd(4'b0110);
        n_vec++; if (shift_q !== 8'h3C) begin n_err++; $display("FAIL prio_load: got %h exp 3c", shift_q); end
        amt = 3'd0;
        do_cmd(4'b0001); model_cmd(4'b0001);
        n_vec++; if (shift_q !== 8'h3C) begin n_err++; $display("FAIL amt_zero: got %h exp 3c", shift_q); end
        do_cmd(4'b1001); model_cmd(4'b1001);
        n_vec++; if (mode_q !== 2'(m_mode)) begin n_err++; $display("FAIL prio_mode: got %b exp %0d", mode_q, m_mode); end
    endtask

    task automatic test_random();
        bit ok; logic [0:6] s; logic p;
        logic [3:0] b;
        for (int it = 0; it < 40; it++) begin
            sw  = 8'($urandom);
            amt = 3'($urandom);
            b   = 4'($urandom_range(1, 15));
            do_cmd(b); model_cmd(b);
            n_vec++; if (shift_q !== m_q || mode_q !== 2'(m_mode))
                begin n_err++; $display("FAIL rand%0d cmd %b: got %h/%b exp %h/%0d", it, b, shift_q, mode_q, m_q, m_mode); end
            if (it % 8 == 7) begin
                for (int d = 0; d < 4; d++) begin
                    logic [15:0] word;
                    logic [3:0]  nib;
                    word = {m_q, sw};
                    nib  = word[d*4 +: 4];
                    grab_digit(d, ok, s, p);
                    n_vec++; if (!ok || s !== hex7(nib) || p !== ~(m_lost && d == 2))
                        begin n_err++; $display("FAIL rand_disp%0d: got ok %0d seg %b dp %b exp seg %b lost %0d", d, ok, s, p, hex7(nib), m_lost); end
                end
            end
        end
    endtask

    task automatic test_scan_reset();
        logic [3:0] exp_an;
        reset = 1'b1; tick(2); reset = 1'b0;
        m_q = 8'h00; m_mode = 0; m_lost = 1'b0;
        tick(1);
        n_vec++; if (an !== 4'b1110) begin n_err++; $display("FAIL scan0: got %b exp 1110", an); end
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            n_vec++; if (an !== exp_an) begin n_err++; $display("FAIL scan%0d: got %b exp %b", k, an, exp_an); end
        end
        tick(4);
        sw = 8'h3F; do_cmd(4'b0100);
        sw = 8'h5A;
        tick(3);
        btn[0] = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        n_vec++; if (an !== 4'hF || shift_q !== 8'h00)
            begin n_err++; $display("FAIL midrst: got an %b q %h exp 1111 00", an, shift_q); end
        tick(1);
        reset = 1'b0;
        tick(1);
        n_vec++; if (an !== 4'b1110) begin n_err++; $display("FAIL midrst_an: got %b exp 1110", an); end
        do_cmd(4'b0100); model_cmd(4'b0100);
        tick(20);
        n_vec++; if (shift_q !== 8'h5A) begin n_err++; $display("FAIL held_noshift: got %h exp 5a", shift_q); end
        btn[0] = 1'b0;
        tick(10);
        amt = 3'd1;
        do_cmd(4'b0001); model_cmd(4'b0001);
        n_vec++; if (shift_q !== 8'h2D) begin n_err++; $display("FAIL repress: got %h exp 2d", shift_q); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bounce();
        test_modes();
        test_priority();
        test_random();
        test_scan_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
